// File: rtl/dbus_dispatch_if.sv
// Bundle of the upstream request/response lines and the per-target downstream lines.
// slave is the dispatcher's view; master is the view of the CPU side plus targets.
interface dbus_dispatch_if #(
    parameter int NUM_TARGETS   = 2,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int PAYLOAD_WIDTH = 40
);
    localparam int SELW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;

    logic                                 in_req;
    logic [SELW-1:0]                      in_sel;
    logic [ADDR_WIDTH-1:0]                in_addr;
    logic [PAYLOAD_WIDTH-1:0]             in_payload;
    logic                                 in_addr_ok;
    logic                                 in_data_ok;
    logic [DATA_WIDTH-1:0]                in_rdata;
    logic [NUM_TARGETS-1:0]               out_req;
    logic [NUM_TARGETS*ADDR_WIDTH-1:0]    out_addr;
    logic [NUM_TARGETS*PAYLOAD_WIDTH-1:0] out_payload;
    logic [NUM_TARGETS-1:0]               out_addr_ok;
    logic [NUM_TARGETS-1:0]               out_data_ok;
    logic [NUM_TARGETS*DATA_WIDTH-1:0]    out_rdata;

    modport slave (
        input  in_req, in_sel, in_addr, in_payload,
        input  out_addr_ok, out_data_ok, out_rdata,
        output in_addr_ok, in_data_ok, in_rdata,
        output out_req, out_addr, out_payload
    );

    modport master (
        output in_req, in_sel, in_addr, in_payload,
        output out_addr_ok, out_data_ok, out_rdata,
        input  in_addr_ok, in_data_ok, in_rdata,
        input  out_req, out_addr, out_payload
    );
endinterface

// File: rtl/dbus_dispatch.sv
// In-order data-bus dispatcher: routes requests to NUM_TARGETS ports and returns
// read data in issue order, buffering early responses in a circular tracking buffer.
module dbus_dispatch #(
    parameter int NUM_TARGETS   = 2,
    parameter int DEPTH         = 4,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int PAYLOAD_WIDTH = 40
) (
    input  logic            clk,
    input  logic            resetn,
    dbus_dispatch_if.slave  bus,
    output logic            busy,
    output logic            err_spurious
);
    localparam int SELW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SELW-1:0]       r_tgt  [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]      r_done;
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [CW-1:0]         r_count;
    logic                  r_issue_done;
    logic                  r_err;

    logic                   w_full;
    logic                   w_sel_ok;
    logic                   w_issue;
    logic                   w_accept;
    logic                   w_head_ok;
    logic                   w_deliver;
    logic [DATA_WIDTH-1:0]  w_head_rdata;
    logic [NUM_TARGETS-1:0] w_hit;
    logic [PW-1:0]          w_idx [NUM_TARGETS];

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign bus.out_addr    = {NUM_TARGETS{bus.in_addr}};
    assign bus.out_payload = {NUM_TARGETS{bus.in_payload}};
    assign busy            = (r_count != '0);
    assign err_spurious    = r_err;

    // No full-bypass: a full buffer refuses even when the head pops this cycle.
    always_comb begin
        w_full      = (r_count == CW'(DEPTH));
        w_sel_ok    = (int'(bus.in_sel) < NUM_TARGETS);
        w_issue     = resetn && bus.in_req && !w_full && !r_issue_done && w_sel_ok;
        w_accept    = 1'b0;
        bus.out_req = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            if (w_issue && int'(bus.in_sel) == i) begin
                bus.out_req[i] = 1'b1;
                w_accept       = bus.out_addr_ok[i];
            end
        end
        bus.in_addr_ok = w_accept;
    end

    // Each responding target claims its oldest undone entry, scanning from the head.
    always_comb begin
        int p;
        p = 0;
        for (int t = 0; t < NUM_TARGETS; t++) begin
            w_hit[t] = 1'b0;
            w_idx[t] = '0;
            for (int k = 0; k < DEPTH; k++) begin
                p = int'(r_head) + k;
                if (p >= DEPTH) p = p - DEPTH;
                if (!w_hit[t] && k < int'(r_count) && int'(r_tgt[p]) == t && !r_done[p]) begin
                    w_hit[t] = 1'b1;
                    w_idx[t] = PW'(p);
                end
            end
        end
    end

    always_comb begin
        w_head_ok    = 1'b0;
        w_head_rdata = r_data[r_head];
        for (int t = 0; t < NUM_TARGETS; t++) begin
            if (int'(r_tgt[r_head]) == t) begin
                w_head_ok = bus.out_data_ok[t];
                if (!r_done[r_head])
                    w_head_rdata = bus.out_rdata[t*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        w_deliver      = resetn && (r_count != '0) && (r_done[r_head] || w_head_ok);
        bus.in_data_ok = w_deliver;
        bus.in_rdata   = w_head_rdata;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_done       <= '0;
            r_issue_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            for (int t = 0; t < NUM_TARGETS; t++) begin
                if (bus.out_data_ok[t]) begin
                    if (w_hit[t]) begin
                        r_done[w_idx[t]] <= 1'b1;
                        r_data[w_idx[t]] <= bus.out_rdata[t*DATA_WIDTH +: DATA_WIDTH];
                    end else begin
                        r_err <= 1'b1;
                    end
                end
            end
            // Clearing done on pop comes after the match so a bypassed head frees cleanly.
            if (w_deliver) begin
                r_done[r_head] <= 1'b0;
                r_head         <= f_inc(r_head);
            end
            if (w_accept) begin
                r_tgt[r_tail]  <= bus.in_sel;
                r_done[r_tail] <= 1'b0;
                r_tail         <= f_inc(r_tail);
            end
            if (w_accept && !w_deliver)
                r_count <= r_count + 1'b1;
            else if (!w_accept && w_deliver)
                r_count <= r_count - 1'b1;
            if (!bus.in_req)
                r_issue_done <= 1'b0;
            else if (w_accept)
                r_issue_done <= 1'b1;
        end
    end
endmodule
